// File: rtl/fetch_unit.sv
// Fetch stage of the SEQ Y86-64 core: owns the PC, splits the instruction bytes
// into fields, computes valP and status, and tracks run/halt and retirements.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             pc_load,
    input  logic [63:0]      pc_next,
    input  logic [7:0]       ibyte0,
    input  logic [7:0]       ibyte1,
    input  logic [7:0]       ibyte2,
    input  logic [7:0]       ibyte3,
    input  logic [7:0]       ibyte4,
    input  logic [7:0]       ibyte5,
    input  logic [7:0]       ibyte6,
    input  logic [7:0]       ibyte7,
    input  logic [7:0]       ibyte8,
    input  logic [7:0]       ibyte9,
    input  logic             imem_error,
    output logic [63:0]      pc,
    output logic [3:0]       icode,
    output logic [3:0]       ifun,
    output logic [3:0]       rA,
    output logic [3:0]       rB,
    output logic [63:0]      valC,
    output logic [63:0]      valP,
    output logic             instr_valid,
    output logic [1:0]       stat,
    output logic             halted,
    output logic [1:0]       halt_stat,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    // The run state is visible on the halted output (halted == state is HALTED).
    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } fetchState_t;

    fetchState_t      stateQ, stateD;
    logic [63:0]      pcQ, pcD;
    logic [CNT_W-1:0] retiredQ, retiredD;
    logic [1:0]       haltStatQ, haltStatD;
    logic             needRegids;
    logic             needValC;

    assign icode = ibyte0[7:4];
    assign ifun  = ibyte0[3:0];

    always_comb begin
        needRegids = 1'b0;
        needValC   = 1'b0;
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: needRegids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                needRegids = 1'b1;
                needValC   = 1'b1;
            end
            4'h7, 4'h8: needValC = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        instr_valid = 1'b0;
        case (icode)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                instr_valid = (ifun == 4'h0);
            4'h2, 4'h7: instr_valid = (ifun <= 4'h6);
            4'h6:       instr_valid = (ifun <= 4'h3);
            default:    instr_valid = 1'b0;
        endcase
    end

    assign rA = needRegids ? ibyte1[7:4] : 4'hF;
    assign rB = needRegids ? ibyte1[3:0] : 4'hF;

    // The constant word starts one byte later when a register-specifier byte is present.
    always_comb begin
        valC = 64'h0;
        if (needValC) begin
            if (needRegids)
                valC = {ibyte9, ibyte8, ibyte7, ibyte6, ibyte5, ibyte4, ibyte3, ibyte2};
            else
                valC = {ibyte8, ibyte7, ibyte6, ibyte5, ibyte4, ibyte3, ibyte2, ibyte1};
        end
    end

    assign valP = pcQ + 64'd1 + {63'd0, needRegids} + {60'd0, needValC, 3'b000};

    always_comb begin
        stat = STAT_AOK;
        if (imem_error)
            stat = STAT_ADR;
        else if (!instr_valid)
            stat = STAT_INS;
        else if (icode == 4'h0)
            stat = STAT_HLT;
    end

    always_comb begin
        stateD    = stateQ;
        pcD       = pcQ;
        retiredD  = retiredQ;
        haltStatD = haltStatQ;
        case (stateQ)
            S_RUN: begin
                if (!stall && pc_load) begin
                    if (stat == STAT_AOK) begin
                        pcD = pc_next;
                        if (retiredQ != {CNT_W{1'b1}})
                            retiredD = retiredQ + CNT_W'(1);
                    end else begin
                        stateD    = S_HALTED;
                        haltStatD = stat;
                    end
                end
            end
            S_HALTED: ;
            default: stateD = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= S_RUN;
            pcQ       <= RESET_PC;
            retiredQ  <= '0;
            haltStatQ <= STAT_AOK;
        end else begin
            stateQ    <= stateD;
            pcQ       <= pcD;
            retiredQ  <= retiredD;
            haltStatQ <= haltStatD;
        end
    end

    assign pc        = pcQ;
    assign halted    = (stateQ == S_HALTED);
    assign halt_stat = haltStatQ;
    assign retired   = retiredQ;

    // STAT_HLT/STAT_INS are named for readability of the encoding set.
    logic unusedStat;
    assign unusedStat = ^{STAT_HLT, STAT_INS};

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan steps followed by randomized instructions,
// all checked against an instruction-length/table based reference model.
module tb_fetch_unit;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Instruction length and highest legal ifun per icode (-1 means illegal icode).
    localparam int LEN_TAB [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    localparam int MAXFUN  [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             pc_load;
    logic [63:0]      pc_next;
    logic [7:0]       ib [10];
    logic             imem_error;
    logic [63:0]      pc;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic [63:0]      valC;
    logic [63:0]      valP;
    logic             instr_valid;
    logic [1:0]       stat;
    logic             halted;
    logic [1:0]       halt_stat;
    logic [CNT_W-1:0] retired;

    int vectors;
    int miscompares;

    logic [63:0]      mPc;
    logic             mHalted;
    logic [1:0]       mHaltStat;
    logic [CNT_W-1:0] mRetired;

    logic [3:0]  eIcode, eIfun, eRA, eRB;
    logic [63:0] eValC, eValP;
    logic        eValid;
    logic [1:0]  eStat;

    fetch_unit #(.RESET_PC(64'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_load(pc_load), .pc_next(pc_next),
        .ibyte0(ib[0]), .ibyte1(ib[1]), .ibyte2(ib[2]), .ibyte3(ib[3]), .ibyte4(ib[4]),
        .ibyte5(ib[5]), .ibyte6(ib[6]), .ibyte7(ib[7]), .ibyte8(ib[8]), .ibyte9(ib[9]),
        .imem_error(imem_error), .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid), .stat(stat), .halted(halted),
        .halt_stat(halt_stat), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelDecode();
        int len;
        int start;
        len    = LEN_TAB[ib[0][7:4]];
        eIcode = ib[0][7:4];
        eIfun  = ib[0][3:0];
        eValid = (MAXFUN[eIcode] >= 0) && (int'(eIfun) <= MAXFUN[eIcode]);
        eRA    = (len == 2 || len == 10) ? ib[1][7:4] : 4'hF;
        eRB    = (len == 2 || len == 10) ? ib[1][3:0] : 4'hF;
        eValC  = 64'h0;
        if (len >= 9) begin
            start = (len == 10) ? 2 : 1;
            for (int k = 0; k < 8; k++)
                eValC = eValC | (64'(ib[start + k]) << (8 * k));
        end
        eValP = mPc + 64'(len);
        if (imem_error)       eStat = 2'b10;
        else if (!eValid)     eStat = 2'b11;
        else if (eIcode == 0) eStat = 2'b01;
        else                  eStat = 2'b00;
    endtask

    task automatic chkState(input string tag);
        chk({tag, ".pc"}, pc, mPc);
        chk({tag, ".halted"}, 64'(halted), 64'(mHalted));
        chk({tag, ".halt_stat"}, 64'(halt_stat), 64'(mHaltStat));
        chk({tag, ".retired"}, 64'(retired), 64'(mRetired));
    endtask

    // Called at a negedge: drive, check decode, clock once, check registered state.
    task automatic step(input string tag, input logic [79:0] bytesLe, input logic [63:0] nxt,
                        input logic ld, input logic stl, input logic err);
        for (int i = 0; i < 10; i++) ib[i] = bytesLe[8*i +: 8];
        pc_next    = nxt;
        pc_load    = ld;
        stall      = stl;
        imem_error = err;
        #1;
        modelDecode();
        chk({tag, ".icode"}, 64'(icode), 64'(eIcode));
        chk({tag, ".ifun"}, 64'(ifun), 64'(eIfun));
        chk({tag, ".rA"}, 64'(rA), 64'(eRA));
        chk({tag, ".rB"}, 64'(rB), 64'(eRB));
        chk({tag, ".valC"}, valC, eValC);
        chk({tag, ".valP"}, valP, eValP);
        chk({tag, ".valid"}, 64'(instr_valid), 64'(eValid));
        chk({tag, ".stat"}, 64'(stat), 64'(eStat));
        @(posedge clk);
        if (!mHalted && !stl && ld) begin
            if (eStat == 2'b00) begin
                mPc = nxt;
                if (mRetired < CNT_MAX) mRetired = mRetired + 1'b1;
            end else begin
                mHalted   = 1'b1;
                mHaltStat = eStat;
            end
        end
        #1;
        chkState(tag);
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; checked before any clock edge can occur.
    task automatic doReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        mPc = 64'h0; mHalted = 1'b0; mHaltStat = 2'b00; mRetired = '0;
        chkState(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Byte lists below are written ibyte0-first, so reverse into little-endian order.
    function automatic logic [79:0] bl(input logic [79:0] msbFirst);
        logic [79:0] r;
        for (int i = 0; i < 10; i++) r[8*i +: 8] = msbFirst[8*(9-i) +: 8];
        return r;
    endfunction

    initial begin
        logic [79:0] rb;
        logic [3:0]  ic;
        logic [3:0]  fn;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; stall = 1'b0; pc_load = 1'b0; pc_next = '0; imem_error = 1'b0;
        for (int i = 0; i < 10; i++) ib[i] = 8'h10;
        mPc = 64'h0; mHalted = 1'b0; mHaltStat = 2'b00; mRetired = '0;
        repeat (2) @(negedge clk);
        chk("reset.pc", pc, 64'h0);
        chk("reset.halted", 64'(halted), 64'h0);
        chk("reset.retired", 64'(retired), 64'h0);
        chk("reset.halt_stat", 64'(halt_stat), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        step("irmovq", bl(80'h30F20A00000000000000), 64'd10, 1, 0, 0);
        chk("irmovq.pc_abs", pc, 64'd10);
        step("jmp_stall", bl(80'h70000100000000000000), 64'h100, 1, 1, 0);
        chk("jmp_stall.pc_abs", pc, 64'd10);
        step("jmp_go", bl(80'h70000100000000000000), 64'h100, 1, 0, 0);
        chk("jmp_go.pc_abs", pc, 64'h100);
        doReset("async_rst");

        step("op_ifun1", bl(80'h61120000000000000000), 64'h20, 1, 0, 0);
        step("op_ifun4", bl(80'h64120000000000000000), 64'h40, 1, 0, 0);
        chk("op_ifun4.hs_abs", 64'(halt_stat), 64'h3);
        step("ins_ignore", bl(80'h10000000000000000000), 64'h55, 1, 0, 0);
        doReset("rst_ins");

        step("halt", bl(80'h00000000000000000000), 64'h55, 1, 0, 0);
        chk("halt.hs_abs", 64'(halt_stat), 64'h1);
        step("halt_ignore", bl(80'h10000000000000000000), 64'h55, 1, 0, 0);
        doReset("rst_hlt");

        step("adr", bl(80'hC0000000000000000000), 64'h77, 1, 0, 1);
        chk("adr.hs_abs", 64'(halt_stat), 64'h2);
        doReset("rst_adr");

        step("to_top", bl(80'h10000000000000000000), 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0);
        step("nop_wrap", bl(80'h10000000000000000000), 64'h8, 0, 0, 0);
        chk("nop_wrap.valP_abs", valP, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int n = 0; n < 400; n++) begin
            if (mHalted && $urandom_range(0, 3) == 0) begin
                doReset("rnd_rst");
            end else begin
                for (int i = 0; i < 10; i++) rb[8*i +: 8] = 8'($urandom);
                ic = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'($urandom_range(1, 11));
                fn = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
                if (ic != 4'h2 && ic != 4'h6 && ic != 4'h7 && $urandom_range(0, 3) != 0) fn = 4'h0;
                rb[7:0] = {ic, fn};
                step("rnd", rb, {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 29) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage of the SEQ Y86-64 core; sits directly downstream of instructionMemory.
- Owns the architectural PC register and presents it to instruction memory.
- Splits the ten returned bytes into icode/ifun/rA/rB/valC, computes valP, and classifies status.
- Tracks run/halt state and a retired-instruction counter; the next PC is supplied by the PC-select logic.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC and state this cycle.
- pc_load  input  1  commit current instruction and load pc_next.
- pc_next  input  64  next PC from PC-select logic.
- ibyte0..ibyte9  input  8 each  instruction bytes at pc..pc+9 from instructionMemory.
- imem_error  input  1  instruction-memory address error for current pc.
- pc  output  64  registered PC, drives instructionMemory.
- icode  output  4  ibyte0[7:4].
- ifun  output  4  ibyte0[3:0].
- rA  output  4  ibyte1[7:4], 4'hF when not needed.
- rB  output  4  ibyte1[3:0], 4'hF when not needed.
- valC  output  64  constant word, little-endian.
- valP  output  64  address of the sequential next instruction.
- instr_valid  output  1  icode/ifun is a legal encoding.
- stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS (combinational for current fetch).
- halted  output  1  core stopped.
- halt_stat  output  2  sticky status latched at halt.
- retired  output  CNT_W  committed instruction count.

Behaviour:
- Reset (async on rst_n low, released synchronously by design):
  - pc=RESET_PC, state RUN, halted=0, halt_stat=00, retired=0.
  - Decode outputs follow the input bytes combinationally during reset as well.
- Decode (combinational, zero latency from ibyte*/pc):
  - need_regids for icode in {2,3,4,5,6,A,B}.
  - need_valC for icode in {3,4,5,7,8}.
  - valC = {ibyte9..ibyte2} if need_regids, else {ibyte8..ibyte1}; 0 if not need_valC.
  - valP = pc + 1 + need_regids + 8*need_valC, modulo 2^64 (wrap allowed, no error).
- Legal encodings:
  - icode 0,1,3,4,5,8,9,A,B with ifun=0.
  - icode 2 and 7 with ifun 0..6.
  - icode 6 with ifun 0..3.
  - All else illegal: instr_valid=0.
- stat priority: imem_error -> ADR; else !instr_valid -> INS; else icode==0 -> HLT; else AOK.
- FSM:
  - RUN: on clk with stall=0 and pc_load=1:
    - If stat==AOK: pc<=pc_next, retired+=1.
    - Else: go to HALTED, halt_stat<=stat, pc unchanged, retired unchanged.
  - RUN, stall=1: no register changes; stall beats pc_load.
  - RUN, pc_load=0: hold.
  - HALTED: pc, retired, and halt_stat frozen; pc_load and stall ignored; halted=1. Exit only via reset.
- retired saturates at all-ones (no wrap).
- Reset asserted mid-operation (including while HALTED) returns to the reset state immediately, without waiting for clk.

Test Plan:
- Reset, then release:
  - pc=0, halted=0, retired=0.
  - Assert rst_n=0 mid-cycle later -> pc returns to 0 asynchronously.
- pc=0, bytes 30 F2 0A 00 00 00 00 00 00 00 (irmovq $10,%rdx):
  - icode=3, ifun=0, rA=F, rB=2, valC=10, valP=10, stat=AOK.
  - pc_load with pc_next=10 -> pc=10, retired=1.
- pc=10, bytes 70 00 01 00 00 00 00 00 00 00 (jmp 0x100):
  - valC=0x100, valP=19, rA=rB=F.
  - pc_load with pc_next=0x100 and stall=1 -> pc stays 10.
  - Same inputs with stall=0 -> pc=0x100.
- Bytes 00 (halt), pc_load:
  - halted=1, halt_stat=HLT, pc unchanged, retired unchanged.
  - Later pc_load with pc_next=0x55 is ignored.
- Bytes 61 ... ifun=1, then bytes 64 (ifun=4):
  - 61: instr_valid=1.
  - 64: instr_valid=0, stat=INS; pc_load -> halt_stat=INS.
- imem_error=1 with bytes C0 (also illegal):
  - stat=ADR (priority over INS).
  - pc_load -> halted=1, halt_stat=ADR.
- pc=64'hFFFF_FFFF_FFFF_FFFE, byte 10 (nop): valP=64'hFFFF_FFFF_FFFF_FFFF, stat=AOK.
